// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single-port unified instruction/data memory of riscv_mc between
// two requesters:
//   port 0 : multicycle core (fetch, load, store)
//   port 1 : external program loader / debug access port
//
// Round-robin arbitration with a registered grant. Only one access is in
// flight at a time. Reads return after a fixed latency, so both requesters
// can simply stall on gnt_o / rvalid_o.
//
// Parameters
//   XLEN    data and address width
//   RD_LAT  memory read latency, access cycle to valid mem_rdata_i (1..4)
//
// Ports
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   req_i[1:0]   per-port request (bit 0 = core, bit 1 = loader)
//   we_i[1:0]    per-port write enable (1 = store)
//   be_i[7:0]    per-port byte enables, port p in be_i[4p+3:4p]
//   addr_i       per-port byte address, port p in addr_i[XLEN*p +: XLEN]
//   wdata_i      per-port write data,   port p in wdata_i[XLEN*p +: XLEN]
//   gnt_o[1:0]   one-hot grant pulse, the access is issued this cycle
//   rvalid_o     one-hot read-data-valid pulse
//   rdata_o      shared read data, qualified by rvalid_o, holds last value
//   busy_o       high whenever the arbiter is not idle
//   mem_en_o     memory access strobe
//   mem_we_o     memory write strobe
//   mem_be_o     memory byte enables (all ones on reads)
//   mem_addr_o   memory byte address
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data
// ============================================================================
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int XLEN   = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [7:0]          be_i,
    input  logic [2*XLEN-1:0]   addr_i,
    input  logic [2*XLEN-1:0]   wdata_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rvalid_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                busy_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    // Counter start value; a 2-bit counter covers the whole 1..4 range.
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t            state_q;
    state_t            state_d;

    logic              pick;
    logic              load_req;
    logic              sel_q;
    logic              last_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [1:0]        cnt_q;
    logic [XLEN-1:0]   rdata_q;

    // Round-robin pick: a lone requester always wins, on a tie the port
    // that was not served last goes first. Only meaningful when req_i != 0.
    always_comb begin
        pick = 1'b0;
        case (req_i)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            default: pick = ~last_q;
        endcase
    end

    // Next-state and output decode. All memory-side outputs are gated by
    // the ACCESS state so they read as zero whenever no access is issued.
    always_comb begin
        state_d     = state_q;
        load_req    = 1'b0;
        gnt_o       = 2'b00;
        rvalid_o    = 2'b00;
        rdata_o     = rdata_q;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    load_req = 1'b1;
                    state_d  = ACCESS;
                end
            end

            ACCESS: begin
                gnt_o       = sel_q ? 2'b10 : 2'b01;
                mem_en_o    = 1'b1;
                mem_we_o    = we_q;
                mem_be_o    = we_q ? be_q : 4'hF;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                state_d     = we_q ? IDLE : RDWAIT;
            end

            RDWAIT: begin
                // Data is passed straight through in the cycle the memory
                // delivers it, so the requester sees it without extra delay.
                if (cnt_q == 2'd0) begin
                    rvalid_o = sel_q ? 2'b10 : 2'b01;
                    rdata_o  = mem_rdata_i;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

    // State register. Reset drops any read in flight, so it can never
    // produce an rvalid_o once reset is released.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture: the winner's attributes are frozen when sampled in
    // IDLE, so the other port (or a requester that drops req early) cannot
    // disturb the access once it has been accepted.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load_req) begin
            sel_q   <= pick;
            if (pick) begin
                we_q    <= we_i[1];
                be_q    <= be_i[7:4];
                addr_q  <= addr_i[2*XLEN-1:XLEN];
                wdata_q <= wdata_i[2*XLEN-1:XLEN];
            end else begin
                we_q    <= we_i[0];
                be_q    <= be_i[3:0];
                addr_q  <= addr_i[XLEN-1:0];
                wdata_q <= wdata_i[XLEN-1:0];
            end
        end
    end

    // Fairness history. Resetting to port 1 lets port 0 win the first tie.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_q <= 1'b1;
        end else if (state_q == ACCESS) begin
            last_q <= sel_q;
        end
    end

    // Read latency counter, loaded when a read is issued and counted down
    // while waiting for the memory.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= 2'd0;
        end else if ((state_q == ACCESS) && !we_q) begin
            cnt_q <= LAT_INIT;
        end else if ((state_q == RDWAIT) && (cnt_q != 2'd0)) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    // Holds the most recently returned read word between rvalid pulses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_q <= '0;
        end else if ((state_q == RDWAIT) && (cnt_q == 2'd0)) begin
            rdata_q <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Two arbiter instances: dut_a with RD_LAT=1 and dut_b with RD_LAT=3, each
// with a small latency-accurate memory model returning an address pattern.
// dut_a is checked by a scoreboard (expected grants queued when requests are
// driven, expected read returns queued at grant time) plus directed timing
// checks; dut_b covers reset during a pending read.
// ============================================================================
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int XLEN  = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_item_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic [31:0] due;
    } rd_item_t;

    logic        clk = 1'b0;
    logic        rstn_a;
    logic        rstn_b;
    logic [1:0]  req_a;
    logic [1:0]  req_b;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;

    logic [1:0]  gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b;
    logic        busy_a, busy_b, mem_en_a, mem_en_b, mem_we_a, mem_we_b;
    logic [3:0]  mem_be_a, mem_be_b;
    logic [31:0] mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
    logic [31:0] mem_rdata_a, mem_rdata_b;

    logic [31:0] pipe_a;
    logic [31:0] pipe_b [0:2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_cnt_a = 0;
    int rvalid_cnt_b = 0;

    gnt_item_t exp_gnt_q [$];
    rd_item_t  exp_rd_q  [$];
    gnt_item_t sb_g;
    rd_item_t  sb_r;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.XLEN(XLEN), .RD_LAT(LAT_A)) dut_a (
        .clk_i(clk), .rstn_i(rstn_a), .req_i(req_a), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .busy_o(busy_a), .mem_en_o(mem_en_a),
        .mem_we_o(mem_we_a), .mem_be_o(mem_be_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a)
    );

    mem_port_arbiter #(.XLEN(XLEN), .RD_LAT(LAT_B)) dut_b (
        .clk_i(clk), .rstn_i(rstn_b), .req_i(req_b), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .busy_o(busy_b), .mem_en_o(mem_en_b),
        .mem_we_o(mem_we_b), .mem_be_o(mem_be_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b)
    );

    function automatic logic [31:0] memPattern(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0051_0093;
        return (a * 32'h0001_0003) ^ 32'hA5A5_5A5A;
    endfunction

    // Memory models: data for an access appears exactly RD_LAT cycles later,
    // any other cycle shows a junk word so mistimed sampling is visible.
    always @(posedge clk) begin
        pipe_a <= (mem_en_a && !mem_we_a) ? memPattern(mem_addr_a) : 32'hBAD0_BAD0;
    end
    assign mem_rdata_a = pipe_a;

    always @(posedge clk) begin
        pipe_b[0] <= (mem_en_b && !mem_we_b) ? memPattern(mem_addr_b) : 32'hBAD0_BAD0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rdata_b = pipe_b[2];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setPort(input int port, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d);
        we[port]            = w;
        be[port*4 +: 4]     = b;
        addr[port*32 +: 32] = a;
        wdata[port*32 +: 32] = d;
    endtask

    task automatic pushExpected(input int port, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] d);
        gnt_item_t it;
        it.port  = (port != 0);
        it.we    = w;
        it.be    = b;
        it.addr  = a;
        it.wdata = d;
        exp_gnt_q.push_back(it);
    endtask

    task automatic applyStimulus(input int port, input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
        setPort(port, w, b, a, d);
        req_a[port] = 1'b1;
        pushExpected(port, w, b, a, d);
    endtask

    task automatic drainA();
        for (int i = 0; i < 200 && (exp_gnt_q.size() != 0 || exp_rd_q.size() != 0); i++)
            @(negedge clk);
        checkOutput("sb_drain", 64'(exp_gnt_q.size() + exp_rd_q.size()), 64'd0);
    endtask

    // Scoreboard monitor for dut_a.
    always @(negedge clk) begin
        if (rstn_a) begin
            checkOutput("gnt_rvalid_excl", 64'((gnt_a != 2'b00) && (rvalid_a != 2'b00)), 64'd0);
            if (gnt_a != 2'b00) begin
                gnt_cnt_a++;
                if (exp_gnt_q.size() == 0) begin
                    checkOutput("gnt_unexpected", 64'(gnt_a), 64'd0);
                end else begin
                    sb_g = exp_gnt_q.pop_front();
                    checkOutput("gnt_port", 64'(gnt_a), sb_g.port ? 64'd2 : 64'd1);
                    checkOutput("gnt_mem_en", 64'(mem_en_a), 64'd1);
                    checkOutput("gnt_mem_we", 64'(mem_we_a), 64'(sb_g.we));
                    checkOutput("gnt_mem_be", 64'(mem_be_a), sb_g.we ? 64'(sb_g.be) : 64'hF);
                    checkOutput("gnt_mem_addr", 64'(mem_addr_a), 64'(sb_g.addr));
                    if (sb_g.we) begin
                        checkOutput("gnt_mem_wdata", 64'(mem_wdata_a), 64'(sb_g.wdata));
                    end else begin
                        sb_r.port = sb_g.port;
                        sb_r.data = memPattern(sb_g.addr);
                        sb_r.due  = 32'(cyc + LAT_A);
                        exp_rd_q.push_back(sb_r);
                    end
                end
            end
            if (rvalid_a != 2'b00) begin
                if (exp_rd_q.size() == 0) begin
                    checkOutput("rvalid_unexpected", 64'(rvalid_a), 64'd0);
                end else begin
                    sb_r = exp_rd_q.pop_front();
                    checkOutput("rvalid_port", 64'(rvalid_a), sb_r.port ? 64'd2 : 64'd1);
                    checkOutput("rvalid_rdata", 64'(rdata_a), 64'(sb_r.data));
                    checkOutput("rvalid_cycle", 64'(cyc), 64'(sb_r.due));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid_b != 2'b00) rvalid_cnt_b++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0;
        req_a = 2'b00; req_b = 2'b00;
        we = 2'b00; be = 8'h00; addr = 64'd0; wdata = 64'd0;

        // Reset with both ports requesting, then continuous reads: 0,1,0,1,0,1.
        setPort(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
        setPort(1, 1'b0, 4'h0, 32'h0000_0200, 32'h0);
        req_a = 2'b11;
        for (int k = 0; k < 6; k++)
            pushExpected(k % 2, 1'b0, 4'h0, (k % 2 != 0) ? 32'h0000_0200 : 32'h0000_0010, 32'h0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ctrl", 64'({gnt_a, rvalid_a, busy_a, mem_en_a, mem_we_a, mem_be_a}), 64'd0);
            checkOutput("rst_addr", 64'(mem_addr_a), 64'd0);
            checkOutput("rst_wdata", 64'(mem_wdata_a), 64'd0);
            checkOutput("rst_rdata", 64'(rdata_a), 64'd0);
        end
        @(posedge clk); #1;
        rstn_a = 1'b1; rstn_b = 1'b1;
        @(negedge clk);
        checkOutput("rel_idle_gnt", 64'(gnt_a), 64'd0);
        @(negedge clk);
        checkOutput("rel_first_gnt", 64'(gnt_a), 64'd1);
        for (int i = 0; i < 100 && gnt_cnt_a < 6; i++) @(negedge clk);
        req_a = 2'b00;
        checkOutput("six_grants", 64'(gnt_cnt_a >= 6), 64'd1);
        drainA();
        repeat (2) @(posedge clk);

        // Single core read of 0x10.
        #1 applyStimulus(0, 1'b0, 4'h0, 32'h0000_0010, 32'h1234_5678);
        @(negedge clk);
        checkOutput("rd_idle", 64'({gnt_a, busy_a}), 64'd0);
        @(negedge clk);
        checkOutput("rd_gnt", 64'(gnt_a), 64'd1);
        checkOutput("rd_busy1", 64'(busy_a), 64'd1);
        req_a[0] = 1'b0;
        @(negedge clk);
        checkOutput("rd_rvalid", 64'(rvalid_a), 64'd1);
        checkOutput("rd_rdata", 64'(rdata_a), 64'h0051_0093);
        checkOutput("rd_busy2", 64'({busy_a, mem_en_a}), 64'd2);
        @(negedge clk);
        checkOutput("rd_done", 64'({busy_a, rvalid_a}), 64'd0);
        checkOutput("rd_hold", 64'(rdata_a), 64'h0051_0093);
        drainA();

        // Loader write of 0xDEADBEEF to 0x100 with be=0011.
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        @(negedge clk);
        checkOutput("wr_gnt", 64'(gnt_a), 64'd2);
        checkOutput("wr_strobes", 64'({mem_en_a, mem_we_a, mem_be_a}), 64'h33);
        checkOutput("wr_wdata", 64'(mem_wdata_a), 64'hDEAD_BEEF);
        req_a[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("wr_quiet", 64'({rvalid_a, mem_en_a, busy_a}), 64'd0);
        end
        drainA();

        // Core request dropped right after sampling still completes.
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 4'h0, 32'h0000_0048, 32'h0);
        @(posedge clk); #1;
        req_a[0] = 1'b0;
        @(negedge clk);
        checkOutput("drop_gnt", 64'(gnt_a), 64'd1);
        @(negedge clk);
        checkOutput("drop_rvalid", 64'(rvalid_a), 64'd1);
        checkOutput("drop_rdata", 64'(rdata_a), 64'(memPattern(32'h0000_0048)));
        drainA();

        // dut_b (RD_LAT=3): reset in the second RDWAIT cycle kills the read.
        @(posedge clk); #1;
        setPort(0, 1'b0, 4'h0, 32'h0000_0040, 32'h0);
        setPort(1, 1'b0, 4'h0, 32'h0000_0080, 32'h0);
        req_b = 2'b01;
        @(negedge clk);
        checkOutput("b_idle_gnt", 64'(gnt_b), 64'd0);
        @(negedge clk);
        checkOutput("b_gnt0", 64'(gnt_b), 64'd1);
        req_b = 2'b11;
        @(posedge clk); #1;
        checkOutput("b_rdwait1", 64'({busy_b, rvalid_b}), 64'h4);
        @(posedge clk); #1;
        rstn_b = 1'b0;
        @(negedge clk);
        checkOutput("b_rst_ctrl", 64'({gnt_b, rvalid_b, busy_b, mem_en_b, mem_we_b, mem_be_b}), 64'd0);
        checkOutput("b_rst_rdata", 64'(rdata_b), 64'd0);
        @(negedge clk);
        checkOutput("b_rst_no_rvalid", 64'(rvalid_b), 64'd0);
        @(posedge clk); #1;
        rstn_b = 1'b1;
        @(negedge clk);
        checkOutput("b_rel_idle", 64'({gnt_b, rvalid_b}), 64'd0);
        @(negedge clk);
        checkOutput("b_tie_port0", 64'(gnt_b), 64'd1);
        req_b = 2'b00;
        for (int i = 0; i < LAT_B - 1; i++) begin
            @(negedge clk);
            checkOutput("b_wait_quiet", 64'(rvalid_b), 64'd0);
        end
        @(negedge clk);
        checkOutput("b_rvalid", 64'(rvalid_b), 64'd1);
        checkOutput("b_rdata", 64'(rdata_b), 64'(memPattern(32'h0000_0040)));
        @(negedge clk);
        checkOutput("b_done_busy", 64'(busy_b), 64'd0);
        checkOutput("b_rvalid_total", 64'(rvalid_cnt_b), 64'd1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
